// File: rtl/accum_readout.sv
// accum_readout: snapshots the accumulator sum once per enable-qualified window
// and streams the per-window delta plus a saturation flag through a 2-deep
// first-word-fall-through buffer. Windows that find the buffer full are counted.
// Optional feature macro: ACCUM_READOUT_AUTOCLR_EN (clear request on saturation).
module accum_readout #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      sum_in,
    input  logic             enable,
    output logic [15:0]      out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             acc_clr
);

    localparam int DATA_W = 16;
    localparam int WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIN_W-1:0]   win_cnt;
    logic [DATA_W-1:0]  prev_snap;

    // snapshot stage (combinational view of the current cycle)
    logic               run_p0;
    logic               snap_p0;
    logic               sat_p0;
    logic [DATA_W-1:0]  delta_p0;

    // buffer storage and bookkeeping
    logic [DATA_W-1:0]  mem_data [2];
    logic               mem_sat  [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    // Drop counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state logic: RUN for exactly the cycles in which enable is high.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign run_p0   = (state_nxt == RUN);
    assign snap_p0  = run_p0 && (win_cnt == WIN_W'(WINDOW - 1));
    assign sat_p0   = (sum_in == {DATA_W{1'b1}});
    assign delta_p0 = sum_in - prev_snap;

    assign full      = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    // An entry pushed this cycle is not yet visible, so it cannot be popped.
    assign pop       = out_valid && out_ready;
    assign push      = snap_p0 && (!full || pop);
    assign drop      = snap_p0 && full && !pop;

    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_sat   = out_valid ? mem_sat[rd_ptr]  : 1'b0;

    // Control state: FSM, window counter, previous snapshot, buffer pointers, drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_cnt   <= '0;
            prev_snap <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            drop_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (snap_p0) begin
                win_cnt <= '0;
`ifdef ACCUM_READOUT_AUTOCLR_EN
                prev_snap <= sat_p0 ? '0 : sum_in;
`else
                prev_snap <= sum_in;
`endif
            end else if (run_p0) begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Buffer payload is data only; validity comes from count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= delta_p0;
            mem_sat[wr_ptr]  <= sat_p0;
        end
    end

`ifdef ACCUM_READOUT_AUTOCLR_EN
    // One-cycle clear request following a saturated snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_clr <= 1'b0;
        else     acc_clr <= snap_p0 && sat_p0;
    end
`else
    assign acc_clr = 1'b0;
`endif

endmodule
